// File: rtl/lu_pkg.sv
// lu_pkg: shared constants for the arbitrated logic unit.
// Holds op encodings and the arbiter FSM state type.
package lu_pkg;

  localparam logic [1:0] OP_OR   = 2'b00;
  localparam logic [1:0] OP_NOR  = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_XNOR = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/lu_arbiter_if.sv
// lu_arbiter_if: two request channels plus one response channel.
// master = requesters/consumer side, slave = arbiter side.
interface lu_arbiter_if #(
  parameter int W = 4
);

  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_x;
  logic [W-1:0] req0_y;
  logic [1:0]   req0_op;

  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_x;
  logic [W-1:0] req1_y;
  logic [1:0]   req1_op;

  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_z;
  logic         rsp_id;

  modport master (
    output req0_valid, req0_x, req0_y, req0_op,
    input  req0_ready,
    output req1_valid, req1_x, req1_y, req1_op,
    input  req1_ready,
    input  rsp_valid, rsp_z, rsp_id,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_x, req0_y, req0_op,
    output req0_ready,
    input  req1_valid, req1_x, req1_y, req1_op,
    output req1_ready,
    output rsp_valid, rsp_z, rsp_id,
    input  rsp_ready
  );

endinterface

// File: rtl/lu_core.sv
// lu_core: combinational W-bit OR/NOR/XOR/XNOR selected by op.
// Ports: x, y operands; op select; z result.
module lu_core
  import lu_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [1:0]   op,
  output logic [W-1:0] z
);

  logic [W-1:0] z_or;
  logic [W-1:0] z_xor;

  assign z_or  = x | y;
  assign z_xor = x ^ y;

  always_comb begin
    z = '0;
    unique case (op)
      OP_OR:   z = z_or;
      OP_NOR:  z = ~z_or;
      OP_XOR:  z = z_xor;
      OP_XNOR: z = ~z_xor;
    endcase
  end

endmodule

// File: rtl/lu_arbiter.sv
// lu_arbiter: round-robin share of one lu_core, registered response.
// Ports: clk, reset_n, bus (slave), cnt0/cnt1 saturating done counts.
module lu_arbiter
  import lu_pkg::*;
#(
  parameter int W  = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  lu_arbiter_if.slave   bus,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1
);

  state_t       state;
  state_t       state_nx;
  logic         rr_ptr;
  logic         rdy0;
  logic         rdy1;
  logic         acc;
  logic         done;
  logic         gnt;
  logic [W-1:0] sel_x;
  logic [W-1:0] sel_y;
  logic [1:0]   sel_op;
  logic [W-1:0] core_z;
  logic [W-1:0] z_q;
  logic         id_q;

  always_comb begin
    state_nx = state;
    rdy0     = 1'b0;
    rdy1     = 1'b0;
    acc      = 1'b0;
    done     = 1'b0;
    case (state)
      ST_IDLE: begin
        rdy0 = bus.req0_valid &
               (!rr_ptr | !bus.req1_valid);
        rdy1 = bus.req1_valid &
               (rr_ptr | !bus.req0_valid);
        acc  = rdy0 | rdy1;
        if (acc) state_nx = ST_BUSY;
      end
      ST_BUSY: begin
        done = bus.rsp_ready;
        if (done) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // rdy1 alone identifies the winner; rdy0/rdy1 never both set
  assign gnt    = rdy1;
  assign sel_x  = gnt ? bus.req1_x  : bus.req0_x;
  assign sel_y  = gnt ? bus.req1_y  : bus.req0_y;
  assign sel_op = gnt ? bus.req1_op : bus.req0_op;

  lu_core #(
    .W (W)
  ) u_core (
    .x  (sel_x),
    .y  (sel_y),
    .op (sel_op),
    .z  (core_z)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      rr_ptr <= 1'b0;
      z_q    <= '0;
      id_q   <= 1'b0;
      cnt0   <= '0;
      cnt1   <= '0;
    end else begin
      state <= state_nx;
      if (acc) begin
        z_q    <= core_z;
        id_q   <= gnt;
        rr_ptr <= ~gnt;
      end
      if (done) begin
        if (!id_q && cnt0 != '1)
          cnt0 <= cnt0 + CW'(1);
        if (id_q && cnt1 != '1)
          cnt1 <= cnt1 + CW'(1);
      end
    end
  end

  // valid derives from async-reset state, so it drops with reset_n
  assign bus.rsp_valid  = (state == ST_BUSY);
  assign bus.rsp_z      = z_q;
  assign bus.rsp_id     = id_q;
  assign bus.req0_ready = rdy0;
  assign bus.req1_ready = rdy1;

endmodule

// File: tb/tb_lu_arbiter.sv
// tb_lu_arbiter: directed checks of lu_arbiter.
// Drives bus via interface, compares against hand-computed values.
module tb_lu_arbiter;

  logic       clk;
  logic       reset_n;
  logic [7:0] cnt0;
  logic [7:0] cnt1;
  int         n_chk;
  int         n_pass;

  lu_arbiter_if #(.W(4)) bus ();

  lu_arbiter #(
    .W  (4),
    .CW (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .cnt0    (cnt0),
    .cnt1    (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_x     = '0;
    bus.req0_y     = '0;
    bus.req0_op    = '0;
    bus.req1_x     = '0;
    bus.req1_y     = '0;
    bus.req1_op    = '0;
    bus.rsp_ready  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
  endtask

  logic [3:0] sweep_exp [4];
  logic [3:0] z_exp;

  initial begin
    n_chk  = 0;
    n_pass = 0;
    sweep_exp[0] = 4'b1110;
    sweep_exp[1] = 4'b0001;
    sweep_exp[2] = 4'b0110;
    sweep_exp[3] = 4'b1001;
    idle_in();
    reset_n = 1'b0;
    #12;
    reset_n = 1'b1;
    #1;

    chk("rst_valid", 32'(bus.rsp_valid), 0);
    chk("rst_z", 32'(bus.rsp_z), 0);
    chk("rst_id", 32'(bus.rsp_id), 0);
    chk("rst_cnt0", 32'(cnt0), 0);
    chk("rst_cnt1", 32'(cnt1), 0);
    chk("rst_rdy0", 32'(bus.req0_ready), 0);
    chk("rst_rdy1", 32'(bus.req1_ready), 0);

    // op sweep on requester 0
    step();
    for (int i = 0; i < 4; i++) begin
      bus.req0_valid = 1'b1;
      bus.req0_x     = 4'b1100;
      bus.req0_y     = 4'b1010;
      bus.req0_op    = 2'(i);
      #1;
      chk("sw_rdy0", 32'(bus.req0_ready), 1);
      step();
      bus.req0_valid = 1'b0;
      bus.req0_op    = 2'b00;
      #1;
      chk("sw_valid", 32'(bus.rsp_valid), 1);
      chk("sw_z", 32'(bus.rsp_z),
          32'(sweep_exp[i]));
      chk("sw_id", 32'(bus.rsp_id), 0);
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
      chk("sw_done", 32'(bus.rsp_valid), 0);
    end
    chk("sw_cnt0", 32'(cnt0), 4);

    // contention from reset, rsp_ready held high
    do_reset();
    bus.req0_x     = 4'b1100;
    bus.req0_y     = 4'b1010;
    bus.req0_op    = 2'b10;
    bus.req1_x     = 4'b1111;
    bus.req1_y     = 4'b0011;
    bus.req1_op    = 2'b00;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.rsp_ready  = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("ct_excl",
          32'(bus.req0_ready & bus.req1_ready), 0);
      chk("ct_rdy1", 32'(bus.req1_ready),
          32'(i % 2));
      step();
      chk("ct_id", 32'(bus.rsp_id), 32'(i % 2));
      z_exp = (i % 2 == 0) ? 4'b0110 : 4'b1111;
      chk("ct_z", 32'(bus.rsp_z), 32'(z_exp));
      chk("ct_busy",
          32'(bus.req0_ready | bus.req1_ready), 0);
      step();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp_ready  = 1'b0;
    #1;
    chk("ct_cnt0", 32'(cnt0), 2);
    chk("ct_cnt1", 32'(cnt1), 2);

    // backpressure on a requester-1 result
    bus.req1_valid = 1'b1;
    bus.req1_x     = 4'b0101;
    bus.req1_y     = 4'b0011;
    bus.req1_op    = 2'b11;
    #1;
    chk("bp_rdy1", 32'(bus.req1_ready), 1);
    step();
    bus.req1_valid = 1'b0;
    bus.req0_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", 32'(bus.rsp_valid), 1);
      chk("bp_z", 32'(bus.rsp_z), 32'(4'b1001));
      chk("bp_id", 32'(bus.rsp_id), 1);
      chk("bp_rdy",
          32'(bus.req0_ready | bus.req1_ready), 0);
      chk("bp_cnt1", 32'(cnt1), 2);
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready  = 1'b0;
    bus.req0_valid = 1'b0;
    chk("bp_cnt1_done", 32'(cnt1), 3);
    chk("bp_cnt0", 32'(cnt0), 2);
    chk("bp_idle", 32'(bus.rsp_valid), 0);

    // saturation: 300 requester-0 transactions
    do_reset();
    bus.req0_valid = 1'b1;
    bus.req0_x     = 4'b1100;
    bus.req0_y     = 4'b1010;
    bus.rsp_ready  = 1'b1;
    for (int i = 0; i < 300; i++) begin
      bus.req0_op = 2'(i % 4);
      step();
      chk("sat_z", 32'(bus.rsp_z),
          32'(sweep_exp[i % 4]));
      chk("sat_valid", 32'(bus.rsp_valid), 1);
      step();
      chk("sat_cnt0", 32'(cnt0),
          (i + 1 > 255) ? 255 : i + 1);
    end
    bus.req0_valid = 1'b0;
    bus.rsp_ready  = 1'b0;
    step();
    chk("sat_hold", 32'(cnt0), 255);
    chk("sat_cnt1", 32'(cnt1), 0);

    // reset while BUSY
    bus.req0_valid = 1'b1;
    bus.req0_op    = 2'b00;
    step();
    bus.req0_valid = 1'b0;
    chk("rb_busy", 32'(bus.rsp_valid), 1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("rb_drop", 32'(bus.rsp_valid), 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rb_cnt0", 32'(cnt0), 0);
    chk("rb_cnt1", 32'(cnt1), 0);
    chk("rb_valid", 32'(bus.rsp_valid), 0);
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    chk("rb_rdy0", 32'(bus.req0_ready), 1);
    chk("rb_rdy1", 32'(bus.req1_ready), 0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
